// File: rtl/branch_pred_pkg.sv
// Shared definitions for the dynamic branch predictor: counter state names
// and saturating counter arithmetic.
package branch_pred_pkg;

  localparam int CNT_MAX_W = 8;

  localparam int SNT = 0;
  localparam int WNT = 1;
  localparam int WT  = 2;
  localparam int ST  = 3;

  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] cnt,
                                                   input int unsigned width);
    int unsigned lim;
    lim = (32'd1 << width) - 32'd1;
    if (32'(cnt) >= lim) return cnt;
    return cnt + CNT_MAX_W'(1);
  endfunction

  function automatic logic [CNT_MAX_W-1:0] sat_dec(input logic [CNT_MAX_W-1:0] cnt,
                                                   input int unsigned width);
    if (cnt == '0 || width == 0) return cnt;
    return cnt - CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One BHT entry: CNT_W-bit saturating up/down counter, reset to weakly-not-taken.
module bp_sat_counter
  import branch_pred_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (up) cnt_d = CNT_W'(sat_inc(CNT_MAX_W'(cnt_q), CNT_W));
      else    cnt_d = CNT_W'(sat_dec(CNT_MAX_W'(cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_RST;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage predictor: tagless BHT of saturating counters plus direct-mapped tagged BTB.
// Define GSHARE_EN to xor a global history register into the BHT index.
module dynamic_branch_predictor
  import branch_pred_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int IDX_BITS = 3,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_W-1:0]     PC_curr,
  output logic                predicted_taken,
  output logic [PC_W-1:0]     predicted_target,
  output logic [IDX_BITS-1:0] pred_ghr,
  input  logic [PC_W-1:0]     IF_ID_PC_curr,
  input  logic [IDX_BITS-1:0] upd_ghr,
  input  logic                wen_BHT,
  input  logic                wen_BTB,
  input  logic                actual_taken,
  input  logic [PC_W-1:0]     actual_target
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = PC_W - IDX_BITS - 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  logic [IDX_BITS-1:0] look_idx, upd_idx, bht_look_idx, bht_upd_idx;
  logic [TAG_W-1:0]    look_tag, upd_tag;

  assign look_idx = PC_curr[IDX_BITS:1];
  assign upd_idx  = IF_ID_PC_curr[IDX_BITS:1];
  assign look_tag = PC_curr[PC_W-1:IDX_BITS+1];
  assign upd_tag  = IF_ID_PC_curr[PC_W-1:IDX_BITS+1];

`ifdef GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (wen_BHT) ghr_d = (ghr_q << 1) | IDX_BITS'(actual_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  // Updates use the history that was live when the branch was predicted.
  assign bht_look_idx = look_idx ^ ghr_q;
  assign bht_upd_idx  = upd_idx ^ upd_ghr;
  assign pred_ghr     = ghr_q;
`else
  logic unused_upd_ghr;
  assign unused_upd_ghr = ^upd_ghr;
  assign bht_look_idx   = look_idx;
  assign bht_upd_idx    = upd_idx;
  assign pred_ghr       = '0;
`endif

  logic unused_upd_lsb;
  assign unused_upd_lsb = IF_ID_PC_curr[0];

  logic [CNT_W-1:0] cnt_all [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
    bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wen_BHT && (bht_upd_idx == IDX_BITS'(i))),
      .up    (actual_taken),
      .cnt   (cnt_all[i])
    );
  end

  // Only the MSB drives prediction; the low bits are hysteresis.
  logic unused_cnt;
  always_comb begin
    unused_cnt = 1'b0;
    for (int i = 0; i < ENTRIES; i++) unused_cnt = unused_cnt ^ (^cnt_all[i]);
  end

  btb_entry_t btb_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else if (wen_BTB) begin
      btb_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: actual_target};
    end
  end

  btb_entry_t look_entry;
  logic       btb_hit, dir_taken;

  assign look_entry       = btb_q[look_idx];
  assign btb_hit          = look_entry.valid && (look_entry.tag == look_tag);
  assign dir_taken        = cnt_all[bht_look_idx][CNT_W-1];
  assign predicted_taken  = dir_taken && btb_hit;
  assign predicted_target = predicted_taken ? look_entry.target : PC_curr + PC_W'(2);

endmodule
